// File: rtl/cp0_unit.sv
// Coprocessor-0 for the five-stage MIPS pipeline: SR/Cause/EPC/PRId plus the
// exception/interrupt request that flushes the pipe and redirects fetch.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2021_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] M_pc,
    input  logic [4:0]  M_EXCcode,
    input  logic        M_BD,
    input  logic [5:0]  HWInt,
    input  logic        eret,
    output logic        Req,
    output logic [31:0] rdata,
    output logic [31:0] EPC
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc_q;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_aligned;

    // Interrupts use the live HWInt lines, not the lagging Cause.IP copy.
    assign int_req    = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req    = (M_EXCcode != 5'd0) & ~sr_exl;
    assign Req        = (int_req | exc_req) & ~reset;
    assign pc_aligned = {M_pc[31:2], 2'b00};
    assign EPC        = epc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                // The flushed instruction's mtc0/eret never takes effect.
                sr_exl    <= 1'b1;
                cause_bd  <= M_BD;
                cause_exc <= int_req ? 5'd0 : M_EXCcode;
                epc_q     <= M_BD ? pc_aligned - 32'd4 : pc_aligned;
            end else begin
                if (we && addr == ADDR_SR) begin
                    sr_im  <= wdata[15:10];
                    sr_exl <= wdata[1];
                    sr_ie  <= wdata[0];
                end
                // Placed after the SR write so eret wins the EXL bit.
                if (eret)
                    sr_exl <= 1'b0;
                if (we && addr == ADDR_EPC)
                    epc_q <= {wdata[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_SR:    rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            ADDR_CAUSE: rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};
            ADDR_EPC:   rdata = epc_q;
            ADDR_PRID:  rdata = PRID;
            default:    rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset values, exception, delay slot, interrupt,
// eret and write-collision cases, checked with immediate assertions.
module tb_cp0_unit;
    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] M_pc;
    logic [4:0]  M_EXCcode;
    logic        M_BD;
    logic [5:0]  HWInt;
    logic        eret;
    logic        Req;
    logic [31:0] rdata;
    logic [31:0] EPC;

    int passed = 0;
    int total  = 0;

    cp0_unit #(.PRID(32'h2021_0007)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
        .M_pc(M_pc), .M_EXCcode(M_EXCcode), .M_BD(M_BD), .HWInt(HWInt),
        .eret(eret), .Req(Req), .rdata(rdata), .EPC(EPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic chk_req(input logic exp, input string tag);
        #1;
        chk(tag, {31'd0, Req}, {31'd0, exp});
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; addr = 5'd0; wdata = 32'd0; M_pc = 32'd0;
        M_EXCcode = 5'd4; M_BD = 1'b0; HWInt = 6'd0; eret = 1'b0;
        step();
        chk_req(1'b0, "req_in_reset");
        rd(5'd12, 32'h0, "rst_sr");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        rd(5'd15, 32'h2021_0007, "prid");
        rd(5'd3, 32'h0, "unmapped");

        reset = 1'b0; M_EXCcode = 5'd0;
        step();
        chk_req(1'b0, "idle_req");

        // Exception, not in delay slot
        M_EXCcode = 5'd10; M_pc = 32'h3010; M_BD = 1'b0;
        chk_req(1'b1, "exc_req");
        step();
        chk_req(1'b0, "exc_masked_by_exl");
        chk("exc_epc_port", EPC, 32'h3010);
        rd(5'd14, 32'h3010, "exc_epc");
        rd(5'd13, 32'h0000_0028, "exc_cause");
        rd(5'd12, 32'h0000_0002, "exc_sr_exl");

        M_EXCcode = 5'd0; eret = 1'b1;
        step();
        eret = 1'b0;
        rd(5'd12, 32'h0, "eret_clr_exl");

        // Delay-slot exception
        M_EXCcode = 5'd4; M_pc = 32'h3024; M_BD = 1'b1;
        chk_req(1'b1, "bd_req");
        step();
        M_EXCcode = 5'd0; M_BD = 1'b0;
        chk("bd_epc", EPC, 32'h3020);
        rd(5'd13, 32'h8000_0010, "bd_cause");
        eret = 1'b1;
        step();
        eret = 1'b0;

        // mtc0 collisions
        we = 1'b1; addr = 5'd14; wdata = 32'h3003;
        step();
        we = 1'b0;
        chk("mtc0_epc_align", EPC, 32'h3000);
        we = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
        step();
        we = 1'b0;
        rd(5'd13, 32'h8000_0010, "mtc0_cause_ignored");

        // Interrupt beats simultaneous exception
        we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
        step();
        we = 1'b0;
        rd(5'd12, 32'h0000_0401, "mtc0_sr");
        HWInt = 6'b000001; M_EXCcode = 5'd12; M_pc = 32'h3040;
        chk_req(1'b1, "int_req");
        step();
        M_EXCcode = 5'd0;
        chk_req(1'b0, "int_masked_by_exl");
        rd(5'd13, 32'h0000_0400, "int_cause");
        chk("int_epc", EPC, 32'h3040);
        rd(5'd12, 32'h0000_0403, "int_sr");

        // eret with interrupt still pending re-raises Req
        eret = 1'b1;
        chk_req(1'b0, "eret_cycle_req");
        step();
        eret = 1'b0;
        rd(5'd12, 32'h0000_0401, "eret_sr");
        chk_req(1'b1, "int_after_eret");
        HWInt = 6'd0;
        chk_req(1'b0, "int_dropped");
        HWInt = 6'b000010;
        chk_req(1'b0, "im_masks");
        HWInt = 6'd0;
        step();

        // mtc0 SR coinciding with Req is discarded
        M_EXCcode = 5'd8; M_pc = 32'h3050;
        we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC00;
        chk_req(1'b1, "collide_req");
        step();
        we = 1'b0; M_EXCcode = 5'd0;
        rd(5'd12, 32'h0000_0403, "collide_sr");
        rd(5'd13, 32'h0000_0020, "collide_cause");

        // eret and mtc0 SR together: eret owns EXL
        eret = 1'b1; we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC03;
        chk_req(1'b0, "eret_mtc0_req");
        step();
        eret = 1'b0; we = 1'b0;
        rd(5'd12, 32'h0000_FC01, "eret_mtc0_sr");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 for the five-stage MIPS pipeline. It receives the exception code, branch-delay flag and PC that travel with each instruction to the M stage, plus six hardware interrupt lines. It decides whether to take an exception or interrupt and drives the single `Req` line. `Req` flushes the pipeline registers and redirects fetch to the handler at 0x0000_4180. It also holds SR, Cause, EPC and PRId for `mfc0`/`mtc0`, and supplies EPC and EXL clearing for `eret`.

## Interface
- `PRID`, default 32'h2021_0007: read-only value returned for register 15.
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `we`  in  1: `mtc0` write enable, from the M stage.
- `addr`  in  5: CP0 register number for read and write.
- `wdata`  in  32: `mtc0` write data.
- `M_pc`  in  32: PC of the instruction in M.
- `M_EXCcode`  in  5: exception code of the M instruction; 0 means none.
- `M_BD`  in  1: the M instruction sits in a branch delay slot.
- `HWInt`  in  6: hardware interrupt lines, level-sensitive.
- `eret`  in  1: an `eret` instruction is in M.
- `Req`  out  1: take exception or interrupt this cycle; combinational.
- `rdata`  out  32: CP0 read data; combinational on `addr`.
- `EPC`  out  32: current EPC register, used as the `eret` target.

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; every other bit reads 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; every other bit reads 0.
  - EPC (14): 32 bits.
  - PRId (15): constant `PRID`.
  - Any other address reads 32'h0.
- Request logic:
  - IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
  - ExcReq = (M_EXCcode != 0) & ~SR.EXL.
  - Req = (IntReq | ExcReq) & ~reset.
- On a clock edge with Req=1:
  - SR.EXL <= 1.
  - Cause.BD <= M_BD.
  - Cause.ExcCode <= IntReq ? 5'd0 : M_EXCcode. An interrupt beats a synchronous exception in the same cycle.
  - EPC <= M_BD ? {M_pc[31:2],2'b00} - 4 : {M_pc[31:2],2'b00}.
- On a clock edge with `eret`=1 and Req=0: SR.EXL <= 0.
- `mtc0` (`we`=1, Req=0):
  - addr 12 writes SR: IM, EXL and IE only.
  - addr 14 writes EPC with {wdata[31:2],2'b00}.
  - Writes to 13, 15 or any other address are ignored.
- Cause.IP <= HWInt on every non-reset edge, independent of all other events.
- Per-field priority on one edge: reset > Req > eret > mtc0.
  - A `we` or `eret` that coincides with Req is discarded; that instruction is flushed.
  - `eret` and an `mtc0` to SR in the same cycle cannot occur in one M stage. If both are asserted, eret wins for EXL and mtc0 still writes IM and IE.
- `rdata` and `EPC` show register contents before the edge. There is no write-through bypass; the forwarding unit covers it.

## Timing
- Reset: SR=0, Cause=0, EPC=0 on the first edge with `reset`=1. While `reset` is high, Req=0.
  - After reset, IE=0, so no interrupt is taken until software sets SR.
  - A nonzero M_EXCcode in the first cycle after reset raises Req.
- Req is combinational in the same cycle as the M inputs. Register updates land at the next edge.
- From that edge, EXL=1 masks further Req until `eret`. Nested exceptions are not supported.
- `eret` clears EXL at the edge. An interrupt that is pending and enabled raises Req in the following cycle.
- HWInt is level-sensitive. Cause.IP lags HWInt by one cycle; IntReq uses the live HWInt.
- Zero-latency reads; one-cycle latency for writes.

## Test plan
- Reset, then read addr 12/13/14/15:
  - 12, 13 and 14 return 0.
  - 15 returns 32'h2021_0007.
  - Req=0 while `reset` is high, even with M_EXCcode=4.
- Exception path:
  - Stimulus: M_EXCcode=5'd10, M_pc=32'h3010, M_BD=0.
  - Same cycle: Req=1.
  - Next cycle: EPC=32'h3010, Cause.ExcCode=10, SR.EXL=1, and Req=0 even though M_EXCcode is still 10.
- Delay-slot exception:
  - Stimulus: M_EXCcode=4, M_pc=32'h3024, M_BD=1.
  - Result: EPC=32'h3020, Cause[31]=1.
- Interrupt path:
  - Stimulus: `mtc0` SR=32'h0000_0401, then HWInt=6'b000001 with M_EXCcode=12 in the same cycle.
  - Result: Req=1, Cause.ExcCode=0, Cause.IP=6'b000001 one cycle later.
  - Repeat with HWInt=6'b000010: IM masks it and Req=0.
- `eret` return:
  - Stimulus: with EXL=1, assert `eret`.
  - Result: EXL=0 after the edge. If HWInt[0] is still high and enabled, Req=1 the next cycle.
- Write collisions:
  - `mtc0` EPC=32'h3003 gives EPC=32'h3000.
  - `mtc0` Cause=32'hFFFF_FFFF: Cause is unchanged.
  - `mtc0` SR in the same cycle as Req=1: SR gets only EXL=1; IM and IE keep their old values.
